// File: rtl/kb_pkg.sv
// Shared types and constants for the HID boot-keyboard report receiver.
package kb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } kb_state_e;

  localparam int         KB_RPT_BYTES    = 8;
  localparam int         KB_FIRST_KEY    = 2;
  localparam int         KB_NUM_KEYS     = KB_RPT_BYTES - KB_FIRST_KEY;
  localparam logic [7:0] KB_KEY_NONE     = 8'h00;
  localparam logic [7:0] KB_KEY_ROLLOVER = 8'h01;

endpackage

// File: rtl/kb_key_select.sv
// Priority picker over the six key slots: first and second nonzero keys,
// plus a flag for the all-0x01 phantom (rollover) report.
module kb_key_select
  import kb_pkg::*;
(
  input  logic [KB_NUM_KEYS-1:0][7:0] slots,
  output logic [7:0]                  key_first,
  output logic [7:0]                  key_second,
  output logic                        rollover
);

  logic [KB_NUM_KEYS-1:0] is_rollover;
  logic                   found_first;
  logic                   found_second;

  generate
    for (genvar gi = 0; gi < KB_NUM_KEYS; gi++) begin : g_roll
      assign is_rollover[gi] = (slots[gi] == KB_KEY_ROLLOVER);
    end
  endgenerate

  assign rollover = &is_rollover;

  // Lowest slot index wins; later nonzero slots only fill the second key.
  always_comb begin
    key_first    = KB_KEY_NONE;
    key_second   = KB_KEY_NONE;
    found_first  = 1'b0;
    found_second = 1'b0;
    for (int i = 0; i < KB_NUM_KEYS; i++) begin
      if (slots[i] != KB_KEY_NONE) begin
        if (!found_first) begin
          key_first   = slots[i];
          found_first = 1'b1;
        end else if (!found_second) begin
          key_second   = slots[i];
          found_second = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kb_report_rx.sv
// Assembles 8-byte HID boot-keyboard reports and commits the key pair atomically.
// Optional idle abort inside a report is enabled by defining KB_TIMEOUT_EN.
module kb_report_rx
  import kb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_sof,
  output logic       byte_ready,
  output logic [7:0] keycode0,
  output logic [7:0] keycode1,
  output logic [7:0] modifier,
  output logic       report_strobe,
  output logic       rollover_err,
  output logic       timeout_err
);

  kb_state_e state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [7:0] rpt_reg [KB_RPT_BYTES];
  logic       xfer;
  logic       timeout_hit;

  logic [KB_NUM_KEYS-1:0][7:0] key_slots;
  logic [7:0] sel_key0, sel_key1;
  logic       sel_rollover;

  logic [7:0] keycode0_reg, keycode1_reg, modifier_reg;
  logic       report_strobe_reg, rollover_err_reg, timeout_err_reg;

  assign byte_ready = (state_reg != COMMIT);
  assign xfer       = byte_valid && byte_ready;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (xfer && byte_sof) begin
          state_next = COLLECT;
          idx_next   = 3'd1;
        end
      end
      COLLECT: begin
        if (xfer) begin
          if (byte_sof) begin
            idx_next = 3'd1;
          end else begin
            idx_next = idx_reg + 3'd1;
            if (idx_reg == 3'(KB_RPT_BYTES - 1)) state_next = COMMIT;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
          idx_next   = 3'd0;
        end
      end
      COMMIT: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

  // Report buffer needs no reset: a report is only committed after a full refill.
  always_ff @(posedge CLK) begin
    if (xfer) begin
      if (byte_sof)                 rpt_reg[0]       <= byte_data;
      else if (state_reg == COLLECT) rpt_reg[idx_reg] <= byte_data;
    end
  end

  generate
    for (genvar gi = 0; gi < KB_NUM_KEYS; gi++) begin : g_slot
      assign key_slots[gi] = rpt_reg[KB_FIRST_KEY + gi];
    end
  endgenerate

  kb_key_select u_key_select (
    .slots      (key_slots),
    .key_first  (sel_key0),
    .key_second (sel_key1),
    .rollover   (sel_rollover)
  );

`ifdef KB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt_reg;

  // A transfer in the terminal cycle takes priority over the abort.
  assign timeout_hit = (state_reg == COLLECT) && !xfer && (idle_cnt_reg == CNT_LAST);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)                          idle_cnt_reg <= '0;
    else if (state_reg != COLLECT || xfer) idle_cnt_reg <= '0;
    else                                   idle_cnt_reg <= idle_cnt_reg + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode0_reg      <= 8'h00;
      keycode1_reg      <= 8'h00;
      modifier_reg      <= 8'h00;
      report_strobe_reg <= 1'b0;
      rollover_err_reg  <= 1'b0;
      timeout_err_reg   <= 1'b0;
    end else begin
      report_strobe_reg <= 1'b0;
      rollover_err_reg  <= 1'b0;
      timeout_err_reg   <= timeout_hit;
      if (state_reg == COMMIT) begin
        if (sel_rollover) begin
          rollover_err_reg <= 1'b1;
        end else begin
          keycode0_reg      <= sel_key0;
          keycode1_reg      <= sel_key1;
          modifier_reg      <= rpt_reg[0];
          report_strobe_reg <= 1'b1;
        end
      end
    end
  end

  // Reserved byte is captured with the rest of the report but never used.
  logic unused_reserved;
  assign unused_reserved = ^rpt_reg[1];

  assign keycode0      = keycode0_reg;
  assign keycode1      = keycode1_reg;
  assign modifier      = modifier_reg;
  assign report_strobe = report_strobe_reg;
  assign rollover_err  = rollover_err_reg;
  assign timeout_err   = timeout_err_reg;

endmodule

// File: doc/kb_report_rx.md
# kb_report_rx

Receives USB HID boot-keyboard reports as a byte stream from the host-side interface and produces the registered `keycode0`/`keycode1` pair consumed by the character motion logic. Reports are assembled byte by byte and committed atomically, so downstream logic never sees a half-updated key pair. The block sits between the host keyboard interface and the character/controller blocks, in the system clock domain.

## Interface
- `TIMEOUT_CYCLES`, default 50000: maximum allowed idle cycles between accepted bytes inside a report (1 ms at 50 MHz). Used only with `KB_TIMEOUT_EN`.
- `CLK`  in  1  system clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `byte_data`  in  8  report byte.
- `byte_valid`  in  1  `byte_data` is valid this cycle.
- `byte_sof`  in  1  qualifies `byte_data` as report byte 0 (modifier byte).
- `byte_ready`  out  1  block accepts a byte this cycle.
- `keycode0`  out  8  first nonzero key slot of the last good report.
- `keycode1`  out  8  second nonzero key slot of the last good report.
- `modifier`  out  8  modifier byte of the last good report.
- `report_strobe`  out  1  one-cycle pulse when the outputs update.
- `rollover_err`  out  1  one-cycle pulse when a phantom (rollover) report is rejected.
- `timeout_err`  out  1  one-cycle pulse when a partial report is aborted.

## Operation
- A byte transfers when `byte_valid && byte_ready` is true on a rising `CLK` edge.
- The report is 8 bytes: modifier, reserved, key slots 2..7.
- States:
  - IDLE: `byte_ready`=1. A transfer with `byte_sof`=1 stores the modifier, sets index 1, and moves to COLLECT. A transfer with `byte_sof`=0 is consumed and discarded.
  - COLLECT: `byte_ready`=1. Each transfer stores the byte at the current index and increments the index. A transfer with `byte_sof`=1 restarts the report: the byte becomes the modifier and the index becomes 1. The transfer at index 7 moves to COMMIT.
  - COMMIT: lasts one cycle with `byte_ready`=0, then returns to IDLE.
- Rollover check in COMMIT: if all six key slots equal 8'h01, all outputs are held, `rollover_err` pulses, and `report_strobe` stays 0.
- Otherwise, in COMMIT:
  - `keycode0` gets the first slot (lowest index) ≠ 8'h00 among slots 2..7.
  - `keycode1` gets the next such slot.
  - A missing key yields 8'h00.
  - `modifier` is updated.
  - `report_strobe` pulses.
- The reserved byte is stored but ignored.
- Reset (asynchronous, any state, including mid-report): state IDLE, index 0, partial report discarded. All outputs are 0 except `byte_ready`=1.

## Timing
- Last-byte handshake in cycle t: COMMIT in cycle t+1. New `keycode0`/`keycode1`/`modifier` and `report_strobe` (or `rollover_err`) are visible in cycle t+2 only. Outputs are registered.
- `byte_ready` is low only in cycle t+1. Minimum report spacing is 9 cycles.
- Outputs change only at commit. Between commits they hold their values indefinitely.
- `byte_valid` with `byte_sof` in the COMMIT cycle is not accepted; the source must hold the byte.

## Configuration
- `KB_TIMEOUT_EN` defined:
  - A 16-bit-minimum idle counter runs in COLLECT and clears on every transfer and on entry to COLLECT.
  - When the counter reaches `TIMEOUT_CYCLES`-1 with no transfer, the next edge returns the state to IDLE, discards the partial report, and pulses `timeout_err` for one cycle.
  - A transfer in that same cycle wins: it is accepted and no timeout occurs.
- `KB_TIMEOUT_EN` undefined: no counter is present. COLLECT waits forever. `timeout_err` is constant 0.

## Structure
- Package `kb_pkg` holds:
  - the state enum (IDLE, COLLECT, COMMIT);
  - `KB_RPT_BYTES`=8;
  - `KB_FIRST_KEY`=2;
  - `KB_KEY_NONE`=8'h00;
  - `KB_KEY_ROLLOVER`=8'h01.
- Sub-module `kb_key_select`: combinational priority picker over the six key slots, returning the first and second nonzero slots and a rollover flag. It is instantiated once, feeding the COMMIT registers.

## Test plan
- Report 00 00 04 00 1A 00 00 00, last byte in cycle t → `keycode0`=04, `keycode1`=1A, `modifier`=00, `report_strobe` high in cycle t+2 only, `byte_ready` low in cycle t+1.
- Report 02 00 01 01 01 01 01 01 after a good 04/1A report → outputs hold 04/1A/00, `rollover_err` pulses once, no `report_strobe`.
- Bytes 00 00 07 (no sof), then report 00 00 00 00 00 16 00 00 → the stray bytes are dropped; `keycode0`=16, `keycode1`=00.
- Bytes 00(sof) 00 04, then 01(sof) 00 1A 00 00 00 00 00 → restart; `modifier`=01, `keycode0`=1A, single strobe.
- With `KB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20:
  - 4 bytes, then a 20-cycle gap → `timeout_err` pulses and no outputs change; a following complete report commits normally.
  - A gap of 19 cycles → no timeout.
- `Reset_n` pulled low after 5 bytes of a report → immediate IDLE, all outputs 0, `byte_ready`=1. A following full report commits correctly.
